// File: rtl/bus_rr_arbit.sv
// 4-master round-robin bus arbiter with bounded tenure; optional m_lock via BUS_ARBIT_LOCK_EN.
// Latency: registered grant visible one cycle after the request is sampled.
// Backpressure: none; an owner keeps the bus until release or tenure expiry (lock extends it).
module bus_rr_arbit #(
    parameter int MAX_TENURE = 8,
    parameter int CNT_W      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] m_req,
`ifdef BUS_ARBIT_LOCK_EN
    input  logic [3:0] m_lock,
`endif
    output logic [3:0] m_grant,
    output logic [1:0] grant_id,
    output logic       bus_busy,
    output logic       handover
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TENURE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       id_q, id_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             handover_q, handover_d;

    logic             own_req;
    logic             lock_hold;
    logic [2:0]       pick_all;
    logic [2:0]       pick_oth;

    // Returns {found, index}; scans last+1 .. last+4 so the previous owner ranks lowest.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign own_req  = |(m_req & grant_q);
`ifdef BUS_ARBIT_LOCK_EN
    assign lock_hold = |(m_req & m_lock & grant_q);
`else
    assign lock_hold = 1'b0;
`endif
    assign pick_all = rr_pick(m_req, last_q);
    // Masking the owner out makes expiry rotate away from it when anyone else waits.
    assign pick_oth = rr_pick(m_req & ~grant_q, last_q);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        id_d       = id_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        handover_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_all[2]) begin
                    state_d = GRANT;
                    id_d    = pick_all[1:0];
                    last_d  = pick_all[1:0];
                    grant_d = 4'b0001 << pick_all[1:0];
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (own_req && (cnt_q < CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (own_req && lock_hold) begin
                    cnt_d = CNT_MAX;
                end else if (pick_oth[2]) begin
                    id_d       = pick_oth[1:0];
                    last_d     = pick_oth[1:0];
                    grant_d    = 4'b0001 << pick_oth[1:0];
                    cnt_d      = '0;
                    handover_d = 1'b1;
                end else if (own_req) begin
                    cnt_d = '0;
                end else begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 4'b0000;
            id_q       <= 2'd0;
            last_q     <= 2'd3;
            cnt_q      <= '0;
            handover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            id_q       <= id_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            handover_q <= handover_d;
        end
    end

    assign m_grant  = grant_q;
    assign grant_id = id_q;
    assign bus_busy = (state_q == GRANT);
    assign handover = handover_q;

endmodule

// File: tb/tb_bus_rr_arbit.sv
// Directed bench for bus_rr_arbit with a scoreboard queue of expected per-cycle outputs.
// Stimulus pushes the expected response for the next edge; a negedge monitor pops and compares.
module tb_bus_rr_arbit;

    typedef struct {
        int         cyc;
        logic [3:0] g;
        logic       ho;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] m_req = 4'b0000;
    logic [3:0] m_lock = 4'b0000;
    logic [3:0] m_grant;
    logic [1:0] grant_id;
    logic       bus_busy;
    logic       handover;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_rr_arbit #(.MAX_TENURE(8), .CNT_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .m_req    (m_req),
`ifdef BUS_ARBIT_LOCK_EN
        .m_lock   (m_lock),
`endif
        .m_grant  (m_grant),
        .grant_id (grant_id),
        .bus_busy (bus_busy),
        .handover (handover)
    );

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Drive inputs for the coming edge and queue what the outputs must show after it.
    task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                        input logic [3:0] eg, input logic eho, input string nm);
        exp_t e;
        @(negedge clk);
        reset  = rst;
        m_req  = req;
        m_lock = lock;
        e.cyc  = cyc + 1;
        e.g    = eg;
        e.ho   = eho;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            checks++;
            if (mon_e.cyc != cyc || m_grant !== mon_e.g || handover !== mon_e.ho ||
                bus_busy !== (mon_e.g != 4'b0000) ||
                (mon_e.g != 4'b0000 && grant_id !== oh2idx(mon_e.g))) begin
                errors++;
                $display("FAIL %s cyc=%0d: got grant=%b ho=%b busy=%b id=%0d, want grant=%b ho=%b busy=%b id=%0d (due cyc %0d)",
                         mon_e.name, cyc, m_grant, handover, bus_busy, grant_id,
                         mon_e.g, mon_e.ho, (mon_e.g != 4'b0000), oh2idx(mon_e.g), mon_e.cyc);
            end
        end
    end

    initial begin
        // 1: reset then idle bus
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "t1_reset");
        for (int k = 0; k < 5; k++) step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "t1_idle");

        // 2: all request from reset, 8-cycle tenures rotating 0,1,2,3,0
        step(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, "t2_reset");
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 4'b1111, 4'b0000, 4'b0001 << ((k / 8) % 4),
                 (k > 0) && (k % 8 == 0), "t2_rotate");
        end
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "t2_release");

        // 3: lone requester keeps the bus across tenure expiry, no gap
        for (int k = 0; k < 20; k++) step(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b0, "t3_lone");
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "t3_release");

        // 4: m0 owns, m2 waits, m0 releases at cnt=3
        step(1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0, "t4_m0_cnt0");
        for (int k = 0; k < 3; k++) step(1'b0, 4'b0101, 4'b0000, 4'b0001, 1'b0, "t4_m0_hold");
        step(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b1, "t4_to_m2");
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "t4_release");

        // 5: reset while m3 owns, then 1001 goes to m0
        step(1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b0, "t5_m3");
        step(1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b0, "t5_m3_hold");
        step(1'b1, 4'b1000, 4'b0000, 4'b0000, 1'b0, "t5_reset");
        step(1'b0, 4'b1001, 4'b0000, 4'b0001, 1'b0, "t5_m0_first");
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "t5_release");

        // 5b: pointer restored to 3 by reset, so m0 beats m1 despite m0 owning last
        step(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "t5b_reset");
        step(1'b0, 4'b0011, 4'b0000, 4'b0001, 1'b0, "t5b_ptr");
        step(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b1, "t5b_to_m1");
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "t5b_release");

        // 7: late request never preempts; rotation only at expiry
        step(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b0, "t7_m1");
        for (int k = 0; k < 7; k++) step(1'b0, 4'b1010, 4'b0000, 4'b0010, 1'b0, "t7_no_preempt");
        step(1'b0, 4'b1010, 4'b0000, 4'b1000, 1'b1, "t7_expire");
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "t7_release");

`ifdef BUS_ARBIT_LOCK_EN
        // 6: locked m2 holds 20 cycles; rotation one cycle after lock drops
        step(1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b0, "t6_m2");
        for (int k = 0; k < 19; k++) step(1'b0, 4'b0101, 4'b0100, 4'b0100, 1'b0, "t6_locked");
        step(1'b0, 4'b0101, 4'b0000, 4'b0001, 1'b1, "t6_unlock");
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "t6_release");
`endif

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations unchecked, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
